game_timer_ctrl: RTL and testbench
==================================

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, clock cycles per game second.
REQ-002 SHALL have parameter STEP_S, default 15, seconds added/removed per up/down press.
REQ-003 SHALL have parameter MIN_S, default 30, lowest settable match time (s).
REQ-004 SHALL have parameter MAX_S, default 240, highest settable match time (s); MAX_S <= 255.
REQ-005 SHALL have parameter INIT_S, default 60, match time after reset (s).
REQ-006 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-007 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports btn_up, btn_down, btn_start  in  1 each  debounced, clk-synchronous button levels.
REQ-009 SHALL have port max_time  out  8  selected match length (s), drives the set-time display.
REQ-010 SHALL have port time_left  out  8  remaining seconds of running match.
REQ-011 SHALL have port state  out  2  SET=0, RUN=1, PAUSE=2, DONE=3.
REQ-012 SHALL have port game_run  out  1  high only in RUN (gates ball/paddle motion).
REQ-013 SHALL have port time_up  out  1  one-cycle pulse when time_left reaches 0.

Function
REQ-014 SHALL act on button rising edges only (level high now, low previous cycle); held buttons produce one action.
REQ-015 In SET, up edge SHALL set max_time = min(max_time+STEP_S, MAX_S); down edge SHALL set max_time = max(max_time-STEP_S, MIN_S); arithmetic 9-bit, no wrap.
REQ-016 Up and down edges in the same cycle SHALL leave max_time unchanged.
REQ-017 Up/down SHALL be ignored in RUN, PAUSE, DONE.
REQ-018 SET + start edge SHALL go to RUN next cycle, load time_left = max_time, clear prescaler.
REQ-019 In RUN the prescaler SHALL count 0..CLK_HZ-1; at CLK_HZ-1 a one-cycle tick SHALL occur and prescaler wraps to 0.
REQ-020 On tick with time_left > 1, time_left SHALL decrement by 1.
REQ-021 On tick with time_left == 1, time_left SHALL become 0, state DONE, time_up high that same cycle only.
REQ-022 First decrement SHALL occur exactly CLK_HZ cycles after entering RUN.
REQ-023 DONE + start edge SHALL go to SET; time_left SHALL hold 0 in DONE, max_time SHALL be retained.
REQ-024 Start edge coinciding with a tick in RUN SHALL give the pause priority (tick discarded) when pause is compiled in.
REQ-025 max_time SHALL never leave [MIN_S, MAX_S].

Reset
REQ-026 rst_n low SHALL immediately force: state SET, max_time INIT_S, time_left 0, prescaler 0, game_run 0, time_up 0.
REQ-027 Previous-button registers SHALL reset to 1 so buttons held through reset produce no edge.
REQ-028 Reset mid-RUN/PAUSE SHALL abandon the match with no time_up pulse.

Configuration
REQ-029 Macro GAME_TIMER_PAUSE_EN defined: start edge in RUN -> PAUSE (prescaler and time_left frozen, game_run 0); start edge in PAUSE -> RUN, prescaler resumes from held value.
REQ-030 Macro undefined: PAUSE unreachable, start edges in RUN ignored, state encoding unchanged.

Structure
REQ-031 State encoding and localparams for state codes SHALL live in shared package pong_pkg.
REQ-032 Button edge detection SHALL be sub-module btn_edge (one instance per button, reset-to-1 history).
REQ-033 Prescaler, FSM and time registers SHALL be in game_timer_ctrl; outputs registered.

Verification (CLK_HZ=4 unless noted)
REQ-034 Reset, 3 up edges -> max_time 60->75->90->105; 20 up edges -> saturates 240; 20 down edges -> 30.
REQ-035 up and down high same cycle at max_time 60 -> max_time stays 60; btn_up held 10 cycles -> +15 once.
REQ-036 max_time 30, start -> RUN, time_left 30; after 4 cycles 29; after 120 cycles 0, time_up one pulse, state DONE; start -> SET, max_time 30.
REQ-037 With GAME_TIMER_PAUSE_EN: RUN, start at prescaler 2 -> PAUSE, 50 cycles no change; start -> RUN, decrement 2 cycles later; without macro start ignored.
REQ-038 rst_n low mid-RUN at time_left 17 -> state SET, time_left 0, max_time 60, no time_up; btn_start held high through reset release -> stays SET.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pkg
//  Purpose  : Shared state encoding and saturating step helpers for the
//             match timer.
//  Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Timer state codes, shared with display/decoder logic elsewhere in the game
  localparam logic [1:0] STATE_SET   = 2'd0;
  localparam logic [1:0] STATE_RUN   = 2'd1;
  localparam logic [1:0] STATE_PAUSE = 2'd2;
  localparam logic [1:0] STATE_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_SET   = STATE_SET,
    ST_RUN   = STATE_RUN,
    ST_PAUSE = STATE_PAUSE,
    ST_DONE  = STATE_DONE
  } game_state_t;

  // Add a step and clamp to the upper bound; 9-bit sum so nothing wraps
  function automatic logic [7:0] step_up(input logic [7:0] cur,
                                         input logic [8:0] step,
                                         input logic [8:0] hi);
    logic [8:0] sum;
    sum = {1'b0, cur} + step;
    if (sum > hi) begin
      return hi[7:0];
    end
    return sum[7:0];
  endfunction

  // Remove a step and clamp to the lower bound; compare first so nothing wraps
  function automatic logic [7:0] step_down(input logic [7:0] cur,
                                           input logic [8:0] step,
                                           input logic [8:0] lo);
    logic [8:0] diff;
    diff = {1'b0, cur} - step;
    if ({1'b0, cur} < (lo + step)) begin
      return lo[7:0];
    end
    return diff[7:0];
  endfunction

endpackage : pong_pkg
`default_nettype wire

// File: rtl/game_timer_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
//  Module   : btn_edge
//  Purpose  : Rising-edge detector for one debounced, clk-synchronous button.
//             History resets to 1 so a button held through reset is silent.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic r_prev;

  // Remember last cycle's level; reset high to suppress a spurious edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_btn;
    end
  end

  assign o_rise = i_btn & ~r_prev;

endmodule : btn_edge
`default_nettype wire

// File: rtl/game_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_timer_ctrl
//  Purpose  : Match timer for the pong game: select match length with up/down,
//             start a countdown clocked by a CLK_HZ prescaler, flag time-up.
//  Config   : define GAME_TIMER_PAUSE_EN to let start toggle RUN <-> PAUSE.
//  Revision : 1.0 - initial release
// ============================================================================
module game_timer_ctrl
  import pong_pkg::*;
#(
  parameter int CLK_HZ = 25000000,
  parameter int STEP_S = 15,
  parameter int MIN_S  = 30,
  parameter int MAX_S  = 240,
  parameter int INIT_S = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [7:0] max_time,
  output logic [7:0] time_left,
  output logic [1:0] state,
  output logic       game_run,
  output logic       time_up
);

  localparam int             PW           = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  c_PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [8:0]     c_STEP       = 9'(STEP_S);
  localparam logic [8:0]     c_MIN        = 9'(MIN_S);
  localparam logic [8:0]     c_MAX        = 9'(MAX_S);
  localparam logic [7:0]     c_INIT       = 8'(INIT_S);

  game_state_t   r_state,     w_state_nxt;
  logic [7:0]    r_max_time,  w_max_nxt;
  logic [7:0]    r_time_left, w_left_nxt;
  logic [PW-1:0] r_presc,     w_presc_nxt;
  logic          r_time_up,   w_time_up_nxt;
  logic          r_game_run;

  logic w_up_rise;
  logic w_down_rise;
  logic w_start_rise;
  logic w_tick;
  logic w_pause_req;

  btn_edge u_edge_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn_up),
    .o_rise (w_up_rise)
  );

  btn_edge u_edge_down (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn_down),
    .o_rise (w_down_rise)
  );

  btn_edge u_edge_start (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn_start),
    .o_rise (w_start_rise)
  );

  // One-second tick, only meaningful while the match is running
  assign w_tick = (r_state == ST_RUN) && (r_presc == c_PRESC_LAST);

`ifdef GAME_TIMER_PAUSE_EN
  assign w_pause_req = w_start_rise;
`else
  assign w_pause_req = 1'b0;
`endif

  // Next-state and next-value logic for the timer FSM and its datapath
  always_comb begin
    w_state_nxt   = r_state;
    w_max_nxt     = r_max_time;
    w_left_nxt    = r_time_left;
    w_presc_nxt   = r_presc;
    w_time_up_nxt = 1'b0;
    case (r_state)
      ST_SET: begin
        if (w_start_rise) begin
          w_state_nxt = ST_RUN;
          w_left_nxt  = r_max_time;
          w_presc_nxt = '0;
        end else if (w_up_rise && !w_down_rise) begin
          w_max_nxt = step_up(r_max_time, c_STEP, c_MAX);
        end else if (w_down_rise && !w_up_rise) begin
          w_max_nxt = step_down(r_max_time, c_STEP, c_MIN);
        end
      end
      ST_RUN: begin
        // Pause wins over a coincident tick; prescaler is held as-is
        if (w_pause_req) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_tick) begin
          w_presc_nxt = '0;
          if (r_time_left > 8'd1) begin
            w_left_nxt = r_time_left - 8'd1;
          end else begin
            w_left_nxt    = 8'd0;
            w_state_nxt   = ST_DONE;
            w_time_up_nxt = 1'b1;
          end
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (w_pause_req) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        w_left_nxt = 8'd0;
        if (w_start_rise) begin
          w_state_nxt = ST_SET;
        end
      end
      default: begin
        w_state_nxt = ST_SET;
      end
    endcase
  end

  // State and datapath registers; outputs come straight from these
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SET;
      r_max_time  <= c_INIT;
      r_time_left <= 8'd0;
      r_presc     <= '0;
      r_time_up   <= 1'b0;
      r_game_run  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_max_time  <= w_max_nxt;
      r_time_left <= w_left_nxt;
      r_presc     <= w_presc_nxt;
      r_time_up   <= w_time_up_nxt;
      r_game_run  <= (w_state_nxt == ST_RUN);
    end
  end

  assign max_time  = r_max_time;
  assign time_left = r_time_left;
  assign state     = r_state;
  assign game_run  = r_game_run;
  assign time_up   = r_time_up;

endmodule : game_timer_ctrl
`default_nettype wire

// File: tb/tb_game_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_timer_ctrl
//  Purpose  : Directed self-checking bench for game_timer_ctrl at CLK_HZ=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_timer_ctrl;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       btn_up    = 1'b0;
  logic       btn_down  = 1'b0;
  logic       btn_start = 1'b0;
  logic [7:0] max_time;
  logic [7:0] time_left;
  logic [1:0] state;
  logic       game_run;
  logic       time_up;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  game_timer_ctrl #(
    .CLK_HZ (4),
    .STEP_S (15),
    .MIN_S  (30),
    .MAX_S  (240),
    .INIT_S (60)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_start (btn_start),
    .max_time  (max_time),
    .time_left (time_left),
    .state     (state),
    .game_run  (game_run),
    .time_up   (time_up)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // which: 0 = up, 1 = down, 2 = start; returns one negedge after the action edge
  task automatic press(input int which);
    @(negedge clk);
    btn_up    = (which == 0);
    btn_down  = (which == 1);
    btn_start = (which == 2);
    @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_tests++; if (max_time !== 8'd60) begin n_fail++; $display("FAIL reset_max: got %0d expected 60", max_time); end
    n_tests++; if (time_left !== 8'd0) begin n_fail++; $display("FAIL reset_left: got %0d expected 0", time_left); end
    n_tests++; if (game_run !== 1'b0 || time_up !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got run=%0b up=%0b expected 0 0", game_run, time_up); end
    rst_n = 1'b1;
  endtask

  task automatic test_up_down();
    for (int i = 0; i < 3; i++) begin
      press(0);
      n_tests++; if (max_time !== 8'(60 + 15 * (i + 1))) begin n_fail++; $display("FAIL up_step%0d: got %0d expected %0d", i, max_time, 60 + 15 * (i + 1)); end
    end
    repeat (20) press(0);
    n_tests++; if (max_time !== 8'd240) begin n_fail++; $display("FAIL up_saturate: got %0d expected 240", max_time); end
    repeat (20) press(1);
    n_tests++; if (max_time !== 8'd30) begin n_fail++; $display("FAIL down_saturate: got %0d expected 30", max_time); end
  endtask

  task automatic test_same_cycle_and_hold();
    apply_reset();
    @(negedge clk); btn_up = 1'b1; btn_down = 1'b1;
    @(negedge clk); btn_up = 1'b0; btn_down = 1'b0;
    n_tests++; if (max_time !== 8'd60) begin n_fail++; $display("FAIL up_down_same: got %0d expected 60", max_time); end
    @(negedge clk); btn_up = 1'b1;
    repeat (10) @(negedge clk);
    btn_up = 1'b0;
    @(negedge clk);
    n_tests++; if (max_time !== 8'd75) begin n_fail++; $display("FAIL up_held: got %0d expected 75", max_time); end
  endtask

  task automatic test_countdown();
    int pulses;
    repeat (3) press(1);
    n_tests++; if (max_time !== 8'd30) begin n_fail++; $display("FAIL set_30: got %0d expected 30", max_time); end
    press(2);
    n_tests++; if (state !== 2'd1 || time_left !== 8'd30 || game_run !== 1'b1) begin n_fail++; $display("FAIL run_entry: got st=%0d left=%0d run=%0b expected 1 30 1", state, time_left, game_run); end
    // up presses in RUN must not move max_time
    btn_up = 1'b1;
    pulses = 0;
    for (int m = 1; m <= 125; m++) begin
      @(negedge clk);
      btn_up = (m % 2 == 0);
      if (time_up) pulses++;
      if (m == 3) begin
        n_tests++; if (time_left !== 8'd30) begin n_fail++; $display("FAIL pre_first_dec: got %0d expected 30", time_left); end
      end
      if (m == 4) begin
        n_tests++; if (time_left !== 8'd29) begin n_fail++; $display("FAIL first_dec: got %0d expected 29", time_left); end
      end
      if (m == 119) begin
        n_tests++; if (time_left !== 8'd1 || state !== 2'd1 || time_up !== 1'b0) begin n_fail++; $display("FAIL last_second: got left=%0d st=%0d up=%0b expected 1 1 0", time_left, state, time_up); end
      end
      if (m == 120) begin
        n_tests++; if (time_left !== 8'd0 || state !== 2'd3 || time_up !== 1'b1 || game_run !== 1'b0) begin n_fail++; $display("FAIL expire: got left=%0d st=%0d up=%0b run=%0b expected 0 3 1 0", time_left, state, time_up, game_run); end
      end
      if (m == 121) begin
        n_tests++; if (time_up !== 1'b0 || state !== 2'd3 || time_left !== 8'd0) begin n_fail++; $display("FAIL done_hold: got up=%0b st=%0d left=%0d expected 0 3 0", time_up, state, time_left); end
      end
    end
    btn_up = 1'b0;
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL time_up_count: got %0d expected 1", pulses); end
    n_tests++; if (max_time !== 8'd30) begin n_fail++; $display("FAIL max_in_run: got %0d expected 30", max_time); end
    press(2);
    n_tests++; if (state !== 2'd0 || max_time !== 8'd30) begin n_fail++; $display("FAIL done_to_set: got st=%0d max=%0d expected 0 30", state, max_time); end
  endtask

  task automatic test_pause();
    press(2);
    @(negedge clk);
    @(negedge clk);
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
`ifdef GAME_TIMER_PAUSE_EN
    n_tests++; if (state !== 2'd2 || game_run !== 1'b0 || time_left !== 8'd30) begin n_fail++; $display("FAIL pause_entry: got st=%0d run=%0b left=%0d expected 2 0 30", state, game_run, time_left); end
    repeat (50) @(negedge clk);
    n_tests++; if (state !== 2'd2 || time_left !== 8'd30) begin n_fail++; $display("FAIL pause_frozen: got st=%0d left=%0d expected 2 30", state, time_left); end
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    n_tests++; if (state !== 2'd1 || game_run !== 1'b1 || time_left !== 8'd30) begin n_fail++; $display("FAIL resume: got st=%0d run=%0b left=%0d expected 1 1 30", state, game_run, time_left); end
    @(negedge clk);
    n_tests++; if (time_left !== 8'd30) begin n_fail++; $display("FAIL resume_hold: got %0d expected 30", time_left); end
    @(negedge clk);
    n_tests++; if (time_left !== 8'd29) begin n_fail++; $display("FAIL resume_dec: got %0d expected 29", time_left); end
`else
    n_tests++; if (state !== 2'd1 || game_run !== 1'b1) begin n_fail++; $display("FAIL start_ignored: got st=%0d run=%0b expected 1 1", state, game_run); end
    @(negedge clk);
    n_tests++; if (time_left !== 8'd29) begin n_fail++; $display("FAIL no_pause_dec: got %0d expected 29", time_left); end
`endif
    apply_reset();
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    pulses = 0;
    press(2);
    for (int m = 1; m <= 172; m++) begin
      @(negedge clk);
      if (time_up) pulses++;
    end
    n_tests++; if (time_left !== 8'd17 || state !== 2'd1) begin n_fail++; $display("FAIL reach_17: got left=%0d st=%0d expected 17 1", time_left, state); end
    #2;
    rst_n = 1'b0;
    btn_start = 1'b1;
    #1;
    n_tests++; if (state !== 2'd0 || time_left !== 8'd0 || max_time !== 8'd60 || game_run !== 1'b0 || time_up !== 1'b0) begin n_fail++; $display("FAIL async_reset: got st=%0d left=%0d max=%0d run=%0b up=%0b expected 0 0 60 0 0", state, time_left, max_time, game_run, time_up); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (time_up) pulses++;
    end
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL held_start: got st=%0d expected 0", state); end
    btn_start = 1'b0;
    @(negedge clk);
    n_tests++; if (state !== 2'd0 || pulses !== 0) begin n_fail++; $display("FAIL post_reset: got st=%0d pulses=%0d expected 0 0", state, pulses); end
  endtask

  initial begin
    test_reset();
    test_up_down();
    test_same_cycle_and_hold();
    test_countdown();
    test_pause();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_game_timer_ctrl
`default_nettype wire
